// File: rtl/hsv2rgb_top.sv
// HSV (Q10.6 hue/sat/val) to RGB565 converter, eight registered stages, one pixel per clock.
// Constant divides use exact reciprocal multiplies after a power-of-two pre-shift.
module hsv2rgb_top #(
  parameter int BRAM_DEPTH = 230400,
  localparam int AW = $clog2(BRAM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [15:0]   i_hue,
  input  logic [15:0]   i_sat,
  input  logic [15:0]   i_val,
  input  logic [AW-1:0] i_addr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_data
);
  localparam int LATENCY = 8;
  localparam logic [15:0] HUE_WRAP = 16'd23040;
  localparam logic [12:0] FULL     = 13'd6400;
  localparam logic [24:0] FULL2    = 25'd24576000;  // 6400 * 3840
  // x/6400 = (x>>8)/25 and x/24576000 = (x>>16)/375; both reciprocals exact for the shifted ranges
  localparam logic [18:0] RCP25    = 19'd335545;    // ceil(2^23/25)
  localparam logic [22:0] RCP375   = 23'd5726624;   // ceil(2^31/375)

  // valid / address side pipe
  logic [LATENCY-1:0] vld_pipe;
  logic [AW-1:0]      addr_pipe [LATENCY];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[LATENCY-2:0], i_valid};
      addr_pipe[0] <= i_addr;
      for (int i = 1; i < LATENCY; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  assign o_valid = vld_pipe[LATENCY-1];
  assign o_addr  = addr_pipe[LATENCY-1];

  // datapath registers
  logic [15:0] s1_h;
  logic [12:0] s1_s, s1_v;
  logic [14:0] s2_h;
  logic [12:0] s2_s, s2_v;
  logic [2:0]  s3_sec;
  logic [11:0] s3_f;
  logic [12:0] s3_s, s3_v;
  logic [2:0]  s4_sec;
  logic [12:0] s4_v, s4_kp;
  logic [24:0] s4_kq, s4_kt;
  logic [2:0]  s5_sec;
  logic [12:0] s5_v;
  logic [17:0] s5_np;
  logic [21:0] s5_nq, s5_nt;
  logic [2:0]  s6_sec;
  logic [12:0] s6_v, s6_p, s6_q, s6_t;
  logic [10:0] s7_rn, s7_gn, s7_bn;

  // combinational helpers
  logic [15:0] h1_c;
  logic [12:0] sat_c, val_c;
  logic [14:0] h2_c, base_c;
  logic [2:0]  sec_c;
  logic [11:0] f_c;
  logic [24:0] sf_c, st_c;
  logic [25:0] np_c;
  logic [37:0] nq_c, nt_c;
  logic [36:0] pp_c;
  logic [44:0] qp_c, tp_c;
  logic [12:0] r_c, g_c, b_c;
  logic [18:0] rn_c, gn_c, bn_c;
  logic [29:0] rq_c, gq_c, bq_c;

  always_comb begin
    h1_c  = (i_hue >= HUE_WRAP) ? i_hue - HUE_WRAP : i_hue;
    sat_c = (i_sat > 16'(FULL)) ? FULL : i_sat[12:0];
    val_c = (i_val > 16'(FULL)) ? FULL : i_val[12:0];
    h2_c  = (s1_h >= HUE_WRAP) ? 15'(s1_h - HUE_WRAP) : s1_h[14:0];
  end

  always_comb begin
    sec_c  = 3'd0;
    base_c = 15'd0;
    if (s2_h >= 15'd19200)      begin sec_c = 3'd5; base_c = 15'd19200; end
    else if (s2_h >= 15'd15360) begin sec_c = 3'd4; base_c = 15'd15360; end
    else if (s2_h >= 15'd11520) begin sec_c = 3'd3; base_c = 15'd11520; end
    else if (s2_h >= 15'd7680)  begin sec_c = 3'd2; base_c = 15'd7680;  end
    else if (s2_h >= 15'd3840)  begin sec_c = 3'd1; base_c = 15'd3840;  end
    f_c = 12'(s2_h - base_c);
  end

  always_comb begin
    sf_c = 25'(s3_s) * 25'(s3_f);
    st_c = 25'(s3_s) * 25'(12'd3840 - s3_f);
    np_c = 26'(s4_v) * 26'(s4_kp);
    nq_c = 38'(s4_v) * 38'(s4_kq);
    nt_c = 38'(s4_v) * 38'(s4_kt);
    pp_c = 37'(s5_np) * 37'(RCP25);
    qp_c = 45'(s5_nq) * 45'(RCP375);
    tp_c = 45'(s5_nt) * 45'(RCP375);
  end

  always_comb begin
    r_c = s6_v;
    g_c = s6_t;
    b_c = s6_p;
    case (s6_sec)
      3'd1:    begin r_c = s6_q; g_c = s6_v; b_c = s6_p; end
      3'd2:    begin r_c = s6_p; g_c = s6_v; b_c = s6_t; end
      3'd3:    begin r_c = s6_p; g_c = s6_q; b_c = s6_v; end
      3'd4:    begin r_c = s6_t; g_c = s6_p; b_c = s6_v; end
      3'd5:    begin r_c = s6_v; g_c = s6_p; b_c = s6_q; end
      default: begin r_c = s6_v; g_c = s6_t; b_c = s6_p; end
    endcase
    // rounding quantise: (x*scale + 3200) / 6400
    rn_c = 19'(r_c) * 19'd31 + 19'd3200;
    gn_c = 19'(g_c) * 19'd63 + 19'd3200;
    bn_c = 19'(b_c) * 19'd31 + 19'd3200;
    rq_c = 30'(s7_rn) * 30'(RCP25);
    gq_c = 30'(s7_gn) * 30'(RCP25);
    bq_c = 30'(s7_bn) * 30'(RCP25);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_h <= '0; s1_s <= '0; s1_v <= '0;
      s2_h <= '0; s2_s <= '0; s2_v <= '0;
      s3_sec <= '0; s3_f <= '0; s3_s <= '0; s3_v <= '0;
      s4_sec <= '0; s4_v <= '0; s4_kp <= '0; s4_kq <= '0; s4_kt <= '0;
      s5_sec <= '0; s5_v <= '0; s5_np <= '0; s5_nq <= '0; s5_nt <= '0;
      s6_sec <= '0; s6_v <= '0; s6_p <= '0; s6_q <= '0; s6_t <= '0;
      s7_rn <= '0; s7_gn <= '0; s7_bn <= '0;
      o_data <= '0;
    end else begin
      s1_h <= h1_c;  s1_s <= sat_c; s1_v <= val_c;
      s2_h <= h2_c;  s2_s <= s1_s;  s2_v <= s1_v;
      s3_sec <= sec_c; s3_f <= f_c; s3_s <= s2_s; s3_v <= s2_v;
      s4_sec <= s3_sec; s4_v <= s3_v;
      s4_kp  <= FULL - s3_s;
      s4_kq  <= FULL2 - sf_c;
      s4_kt  <= FULL2 - st_c;
      s5_sec <= s4_sec; s5_v <= s4_v;
      s5_np  <= np_c[25:8];
      s5_nq  <= nq_c[37:16];
      s5_nt  <= nt_c[37:16];
      s6_sec <= s5_sec; s6_v <= s5_v;
      s6_p   <= pp_c[35:23];
      s6_q   <= qp_c[43:31];
      s6_t   <= tp_c[43:31];
      s7_rn  <= rn_c[18:8];
      s7_gn  <= gn_c[18:8];
      s7_bn  <= bn_c[18:8];
      o_data <= {rq_c[27:23], gq_c[28:23], bq_c[27:23]};
    end
  end

  // discarded fractional / headroom bits of the reciprocal products
  logic unused_bits;
  assign unused_bits = ^{np_c[7:0], nq_c[15:0], nt_c[15:0], pp_c[36], pp_c[22:0],
                         qp_c[44], qp_c[30:0], tp_c[44], tp_c[30:0],
                         rn_c[7:0], gn_c[7:0], bn_c[7:0],
                         rq_c[29:28], rq_c[22:0], gq_c[29], gq_c[22:0],
                         bq_c[29:28], bq_c[22:0]};

endmodule

// File: tb/tb_hsv2rgb_top.sv
// Scoreboard bench for hsv2rgb_top: stimulus pushes expected pixels, a negedge monitor pops and checks.
module tb_hsv2rgb_top;
  localparam int AW = $clog2(230400);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [15:0]   hue = '0, sat = '0, val = '0;
  logic [AW-1:0] addr = '0;
  logic          o_valid;
  logic [AW-1:0] o_addr;
  logic [15:0]   o_data;

  hsv2rgb_top #(.BRAM_DEPTH(230400)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_hue(hue), .i_sat(sat),
    .i_val(val), .i_addr(addr), .o_valid(o_valid), .o_addr(o_addr), .o_data(o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] next_addr = AW'(5);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: straight from the colour-space definition using wide integer division.
  function automatic logic [15:0] model(input logic [15:0] hi, input logic [15:0] si,
                                        input logic [15:0] vi);
    longint h, s, v, sec, f, p, q, t, r, g, b, r5, g6, b5;
    h = hi;
    while (h >= 23040) h -= 23040;
    s = (si > 6400) ? 6400 : si;
    v = (vi > 6400) ? 6400 : vi;
    sec = h / 3840;
    f = h % 3840;
    p = v * (6400 - s) / 6400;
    q = v * (24576000 - s * f) / 24576000;
    t = v * (24576000 - s * (3840 - f)) / 24576000;
    case (sec)
      0: begin r = v; g = t; b = p; end
      1: begin r = q; g = v; b = p; end
      2: begin r = p; g = v; b = t; end
      3: begin r = p; g = q; b = v; end
      4: begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
    r5 = (r * 31 + 3200) / 6400;
    g6 = (g * 63 + 3200) / 6400;
    b5 = (b * 31 + 3200) / 6400;
    return 16'((r5 << 11) | (g6 << 5) | b5);
  endfunction

  task automatic drive(input logic v, input logic [15:0] h, input logic [15:0] s,
                       input logic [15:0] vv, input logic [15:0] exp);
    @(posedge clk);
    #1;
    valid = v; hue = h; sat = s; val = vv;
    if (v) begin
      addr = next_addr;
      sb.push_back('{cyc + 8, next_addr, exp});
      next_addr = next_addr + 1'b1;
    end else begin
      addr = AW'($urandom);
    end
  endtask

  function automatic logic [15:0] rnd_hue();
    return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 23039));
  endfunction

  function automatic logic [15:0] rnd_pct();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return 16'd6400;
      2:       return 16'($urandom);
      default: return 16'($urandom_range(0, 6400));
    endcase
  endfunction

  task automatic rand_pixel(input logic v);
    logic [15:0] h, s, vv;
    h = rnd_hue(); s = rnd_pct(); vv = rnd_pct();
    drive(v, h, s, vv, model(h, s, vv));
  endtask

  // monitor: every o_valid must match the oldest expected pixel at exactly its due cycle
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("o_valid idle", 32'(o_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("latency", cyc, mon_e.due);
        check("o_addr", 32'(o_addr), 32'(mon_e.addr));
        check("o_data", 32'(o_data), 32'(mon_e.data));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check("o_valid due", 32'(o_valid), 32'd1);
    end
  end

  logic [15:0] dh [10] = '{16'd0, 16'd7680, 16'd3840, 16'd1920, 16'd12345,
                           16'd5000, 16'd65535, 16'd23040, 16'd46080, 16'd0};
  logic [15:0] ds [10] = '{16'd6400, 16'd6400, 16'd6400, 16'd6400, 16'd0,
                           16'd3000, 16'd65535, 16'd6400, 16'd6400, 16'd65535};
  logic [15:0] dv [10] = '{16'd6400, 16'd6400, 16'd6400, 16'd6400, 16'd6400,
                           16'd0, 16'd0, 16'd6400, 16'd6400, 16'd65535};
  logic [15:0] de [10] = '{16'hF800, 16'h07E0, 16'hFFE0, 16'hFC00, 16'hFFFF,
                           16'h0000, 16'h0000, 16'hF800, 16'hF800, 16'hF800};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset o_valid", 32'(o_valid), 32'd0);
    check("reset o_addr", 32'(o_addr), 32'd0);
    check("reset o_data", 32'(o_data), 32'd0);
    rst = 1'b0;

    // directed corners, first one at addr 5, then again with gaps
    for (int i = 0; i < 10; i++) drive(1'b1, dh[i], ds[i], dv[i], de[i]);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'h0);
      drive(1'b1, dh[i], ds[i], dv[i], de[i]);
    end

    for (int i = 0; i < 400; i++) rand_pixel(1'($urandom_range(0, 1)));

    // mid-stream reset with eight pixels in flight
    for (int i = 0; i < 8; i++) rand_pixel(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid = 1'b0;
    sb.delete();
    #1;
    check("rst o_valid", 32'(o_valid), 32'd0);
    check("rst o_addr", 32'(o_addr), 32'd0);
    check("rst o_data", 32'(o_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rand_pixel(1'b0);
    for (int i = 0; i < 200; i++) rand_pixel(1'($urandom_range(0, 1)));

    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int w = 0; w < 30 && sb.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    check("drain pending", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
